conv_sequencer: RTL and testbench

Central controller for the sliding-window convolution datapath. It walks the output grid row by row, runs the LOAD/SHIFT/CONVOLVE/STORE handshake with the window buffer and MAC units, and writes each result to output BRAM port A. When the grid is complete it reads the BRAM back over the same port and streams the results on a valid/ready interface.

---
 rtl/conv_sequencer_pkg.sv | 27 ++
 rtl/conv_sequencer_bram_stream_reader.sv | 90 +++++++++
 rtl/conv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_conv_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sequencer_pkg.sv
// Shared encodings for the convolution sequencer and its BRAM stream reader.
package conv_pkg;

    localparam int RES_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PROCESS  = 2'd1,
        ST_STREAM   = 2'd2,
        ST_COMPLETE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PS_LOAD     = 2'd0,
        PS_SHIFT    = 2'd1,
        PS_CONVOLVE = 2'd2,
        PS_STORE    = 2'd3
    } proc_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        RD_VALID = 2'd3
    } rd_state_e;

endpackage

// File: rtl/conv_sequencer_bram_stream_reader.sv
// Reads DEPTH words back from the output BRAM and presents them on a valid/ready port.
// Handshake: m_data_o/m_valid_o are held stable until a cycle with m_valid_o && m_ready_i.
module bram_stream_reader
    import conv_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int BRAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [RES_W-1:0]  rd_data_i,
    output logic [RES_W-1:0]  m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              last_o
);

    localparam int LAT_W = $clog2(BRAM_LAT + 1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [RES_W-1:0]  data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            lat_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        data_d  = data_q;
        last_o  = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (start_i) begin
                    addr_d  = '0;
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                lat_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // lat_q counts the cycles since issue; read data is valid on the last one
                if (lat_q == LAT_W'(BRAM_LAT - 1)) begin
                    data_d  = rd_data_i;
                    state_d = RD_VALID;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RD_VALID: begin
                if (m_ready_i) begin
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        last_o  = 1'b1;
                        addr_d  = '0;
                        state_d = RD_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    assign rd_en_o   = (state_q == RD_ISSUE);
    assign rd_addr_o = addr_q;
    assign m_data_o  = data_q;
    assign m_valid_o = (state_q == RD_VALID);

endmodule

// File: rtl/conv_sequencer.sv
// Walks the output grid through LOAD/SHIFT/CONVOLVE/STORE, writes results to BRAM port A,
// then streams them back out. Enables are level requests held until the matching done.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter  int IMAGE_WIDTH  = 128,
    parameter  int IMAGE_HEIGHT = 128,
    parameter  int FILTER_SIZE  = 3,
    parameter  int BRAM_LAT     = 2,
    localparam int OUT_W  = IMAGE_WIDTH - FILTER_SIZE + 1,
    localparam int OUT_H  = IMAGE_HEIGHT - FILTER_SIZE + 1,
    localparam int ADDR_W = $clog2(OUT_W * OUT_H),
    localparam int CNT_W  = $clog2(((OUT_W > OUT_H) ? OUT_W : OUT_H) + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              load_en,
    input  logic              load_done,
    output logic              shift_en,
    input  logic              shift_done,
    output logic              conv_en,
    input  logic              convolve_done,
    input  logic [RES_W-1:0]  result_in,
    output logic              out_en,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [RES_W-1:0]  out_din,
    input  logic [RES_W-1:0]  out_dout,
    output logic [RES_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [1:0]        state,
    output logic [1:0]        process_state,
    output logic [CNT_W-1:0]  row_count,
    output logic [CNT_W-1:0]  col_count,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    proc_e             ps_q, ps_d;
    logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              rd_start, rd_last, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              in_proc, wr_cyc, col_last, row_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ps_q    <= PS_LOAD;
            row_q   <= '0;
            col_q   <= '0;
            wr_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wr_q    <= wr_d;
            res_q   <= res_d;
        end
    end

    assign col_last = (col_q == CNT_W'(OUT_W - 1));
    assign row_last = (row_q == CNT_W'(OUT_H - 1));

    always_comb begin
        state_d  = state_q;
        ps_d     = ps_q;
        row_d    = row_q;
        col_d    = col_q;
        wr_d     = wr_q;
        res_d    = res_q;
        rd_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_COMPLETE: begin
                if (start) begin
                    state_d = ST_PROCESS;
                    ps_d    = PS_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    wr_d    = '0;
                end
            end
            ST_PROCESS: begin
                case (ps_q)
                    PS_LOAD:  if (load_done)  ps_d = PS_CONVOLVE;
                    PS_SHIFT: if (shift_done) ps_d = PS_CONVOLVE;
                    PS_CONVOLVE: begin
                        if (convolve_done) begin
                            res_d = result_in;
                            ps_d  = PS_STORE;
                        end
                    end
                    PS_STORE: begin
                        // wr_q tracks row*OUT_W+col by simple increment
                        wr_d = wr_q + 1'b1;
                        if (col_last) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                            ps_d  = PS_LOAD;
                            if (row_last) begin
                                row_d    = '0;
                                wr_d     = '0;
                                state_d  = ST_STREAM;
                                rd_start = 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                            ps_d  = PS_SHIFT;
                        end
                    end
                    default: ps_d = PS_LOAD;
                endcase
            end
            ST_STREAM: begin
                if (rd_last) state_d = ST_COMPLETE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    bram_stream_reader #(
        .DEPTH    (OUT_W * OUT_H),
        .ADDR_W   (ADDR_W),
        .BRAM_LAT (BRAM_LAT)
    ) u_reader (
        .clk       (clk),
        .rst       (rst),
        .start_i   (rd_start),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (out_dout),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .last_o    (rd_last)
    );

    assign in_proc  = (state_q == ST_PROCESS);
    assign wr_cyc   = in_proc && (ps_q == PS_STORE);
    assign load_en  = in_proc && (ps_q == PS_LOAD);
    assign shift_en = in_proc && (ps_q == PS_SHIFT);
    assign conv_en  = in_proc && (ps_q == PS_CONVOLVE);

    // Port A is shared: writes only from STORE, reads only from the stream reader
    assign out_en   = wr_cyc || rd_en;
    assign out_we   = wr_cyc;
    assign out_addr = wr_cyc ? wr_q : rd_addr;
    assign out_din  = wr_cyc ? res_q : '0;

    assign state         = state_q;
    assign process_state = ps_q;
    assign row_count     = row_q;
    assign col_count     = col_q;
    assign busy          = (state_q == ST_PROCESS) || (state_q == ST_STREAM);
    assign done          = (state_q == ST_COMPLETE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer on a 6x6 image with a 3x3 filter (4x4 output grid).
module tb_conv_sequencer;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 3;
    localparam int NWORDS = 16;

    logic              clk, rst, start;
    logic              load_en, load_done, shift_en, shift_done, conv_en, convolve_done;
    logic [31:0]       result_in;
    logic              out_en, out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_din, out_dout, m_data;
    logic              m_valid, m_ready;
    logic [1:0]        state, process_state;
    logic [CNT_W-1:0]  row_count, col_count;
    logic              busy, done;

    int checks = 0;
    int errors = 0;

    conv_sequencer #(
        .IMAGE_WIDTH  (6),
        .IMAGE_HEIGHT (6),
        .FILTER_SIZE  (3),
        .BRAM_LAT     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .load_en       (load_en),
        .load_done     (load_done),
        .shift_en      (shift_en),
        .shift_done    (shift_done),
        .conv_en       (conv_en),
        .convolve_done (convolve_done),
        .result_in     (result_in),
        .out_en        (out_en),
        .out_we        (out_we),
        .out_addr      (out_addr),
        .out_din       (out_din),
        .out_dout      (out_dout),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .state         (state),
        .process_state (process_state),
        .row_count     (row_count),
        .col_count     (col_count),
        .busy          (busy),
        .done          (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard state
    logic [31:0] exp_q[$];
    logic [31:0] mem [NWORDS];
    logic [31:0] p1, p2;
    int  cyc = 0;
    int  cnt_l = 0, cnt_s = 0, cnt_c = 0;
    int  conv_idx = 0, wr_k = 0, loads = 0, shifts = 0, hs_n = 0, hs_last = 0, spur_cnt = 0;
    bit  mon_on = 0, rand_ready = 0, spur_on = 0, spur_now = 0, spur_prev = 0;
    logic prev_valid = 0, prev_ready = 0, prev_load = 0, prev_shift = 0;
    logic [31:0] prev_data = '0, exp_word;

    // driver: done responses, m_ready, BRAM model; then monitor
    initial begin
        load_done = 0; shift_done = 0; convolve_done = 0; result_in = '0;
        m_ready = 1'b1; out_dout = '0; p1 = '0; p2 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                cnt_l = 0; cnt_s = 0; cnt_c = 0;
                load_done = 0; shift_done = 0; convolve_done = 0; result_in = '0;
                spur_prev = 0; prev_valid = 0; prev_ready = 0; prev_load = 0; prev_shift = 0;
                continue;
            end
            cnt_l = load_en  ? cnt_l + 1 : 0;
            cnt_s = shift_en ? cnt_s + 1 : 0;
            cnt_c = conv_en  ? cnt_c + 1 : 0;
            load_done     = (cnt_l == 2);
            shift_done    = (cnt_s == 2);
            convolve_done = (cnt_c == 2);
            result_in     = '0;
            if (convolve_done) begin
                result_in = 32'(100 + conv_idx);
                conv_idx++;
            end
            spur_now = 0;
            if (spur_on && cnt_l == 1) begin
                shift_done = 1; convolve_done = 1; result_in = 32'hDEADBEEF;
                spur_now = 1; spur_cnt++;
            end
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

            out_dout = p2;
            p2 = p1;
            p1 = (out_en && !out_we) ? mem[out_addr] : 32'hBAD0_0BAD;
            if (out_en && out_we) mem[out_addr] = out_din;

            if (mon_on) begin
                if (out_en)
                    check("port_owner", {127'b0, (state == 2'd1 && process_state == 2'd3) ||
                                         (state == 2'd2 && !out_we)}, 128'd1);
                if (out_en && out_we) begin
                    check("wr_addr", out_addr, wr_k[ADDR_W-1:0]);
                    check("wr_data", out_din, 32'(100 + wr_k));
                    wr_k++;
                end
                if (load_en && !prev_load) begin
                    loads++;
                    check("load_col0", col_count, 0);
                end
                if (shift_en && !prev_shift) begin
                    shifts++;
                    check("shift_col", {127'b0, col_count != 0}, 128'd1);
                end
                if (spur_prev)
                    check("spur_hold", {state, process_state}, {2'd1, 2'd0});
                if (prev_valid && !prev_ready)
                    check("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
                if (m_valid && m_ready) begin
                    exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                    check("stream_data", m_data, exp_word);
                    if (!rand_ready && hs_n > 0) check("stream_rate", cyc - hs_last, 4);
                    hs_last = cyc;
                    hs_n++;
                end
            end
            spur_prev  = spur_now;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_load  = load_en;
            prev_shift = shift_en;
        end
    end

    task automatic wait_frame_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {127'b0, n < 2000}, 128'd1);
    endtask

    task automatic frame_checks();
        check("wr_count", wr_k, NWORDS);
        check("loads", loads, 4);
        check("shifts", shifts, 12);
        check("hs_count", hs_n, NWORDS);
        check("exp_empty", exp_q.size(), 0);
        check("end_flags", {done, busy, out_en, state}, {1'b1, 1'b0, 1'b0, 2'd3});
    endtask

    task automatic frame_setup();
        conv_idx = 0; wr_k = 0; loads = 0; shifts = 0; hs_n = 0; spur_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back(32'(100 + i));
    endtask

    // directed sequence
    initial begin
        int n;
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_all_zero", {load_en, shift_en, conv_en, out_en, out_we, out_addr, out_din,
                               m_data, m_valid, state, process_state, row_count, col_count,
                               busy, done}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_zero", {load_en, shift_en, conv_en, out_en, out_we, out_addr, out_din,
                                m_data, m_valid, state, process_state, row_count, col_count,
                                busy, done}, 128'd0);

        // abort mid-frame in CONVOLVE at row 1, col 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(row_count == 3'd1 && col_count == 3'd2 && process_state == 2'd2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_r1c2", {127'b0, n < 500}, 128'd1);
        rst = 1'b1;
        #1;
        check("abort_now", {state, load_en, shift_en, conv_en, out_en, m_valid, row_count, col_count}, 128'd0);
        @(negedge clk);
        check("abort_next", {state, load_en, shift_en, conv_en, out_en, m_valid, row_count, col_count}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // frame 1: m_ready high, start pulses while busy
        frame_setup();
        mon_on = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart", {state, process_state, row_count, col_count, busy}, {2'd1, 2'd0, 3'd0, 3'd0, 1'b1});
        n = 0;
        while (row_count != 3'd2 && n < 500) begin @(negedge clk); n++; end
        check("reach_row2", {127'b0, n < 500}, 128'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (state != 2'd2 && n < 500) begin @(negedge clk); n++; end
        check("reach_stream", {127'b0, n < 500}, 128'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_stream", {state, busy}, {2'd2, 1'b1});
        wait_frame_done("frame1_done");
        frame_checks();

        // frame 2 from COMPLETE: random m_ready, spurious done pulses in LOAD
        frame_setup();
        rand_ready = 1; spur_on = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart2", {state, process_state, row_count, col_count}, {2'd1, 2'd0, 3'd0, 3'd0});
        wait_frame_done("frame2_done");
        frame_checks();
        check("spur_count", spur_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
